sort_sequencer: RTL and testbench
=================================

# sort_sequencer

Sorting controller that time-shares a single unsigned strict greater-than comparator across a small register file. It accepts a burst of DEPTH words and sorts them in place with a bubble sort, one compare per cycle. It then streams the words out in ascending order. It sits between a producer and a consumer in the comparator datapath, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 4, data word width; compare is unsigned. At WIDTH=4 the team's `greaterThan` comparator (i_a, i_b -> o_ab) is instantiated as the shared compare unit.
- DEPTH, 4, words per burst; legal range 2..16.
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  input word valid.
- o_ready  out  1  block accepts input (LOAD state only).
- i_data  in  WIDTH  input word.
- o_valid  out  1  output word valid (OUT state only).
- i_ready  in  1  consumer accepts output.
- o_data  out  WIDTH  output word.
- o_busy  out  1  high in SORT state.
- o_done  out  1  one-cycle pulse on the SORT->OUT transition.

## Operation
- States:
  - LOAD (reset state): o_ready=1. Each cycle with i_valid&o_ready writes i_data to mem[wr_idx] and increments wr_idx. The DEPTH-th accept moves the block to SORT and clears wr_idx.
  - SORT: compare index j steps 0..DEPTH-2 in each pass; pass counter p steps 0..DEPTH-2.
    - Each cycle: a=mem[j], b=mem[j+1]. If a>b (strict), swap the pair at the clock edge and set swap_flag.
    - Equal words are never swapped, so the sort is stable.
    - End of pass (j=DEPTH-2): clear swap_flag, j=0, p+1.
  - OUT: o_data=mem[rd_idx], o_valid=1. rd_idx advances on each o_valid&i_ready. After the DEPTH-th transfer, go to LOAD with rd_idx=0.
- Inputs ignored outside their state: i_valid outside LOAD, i_ready outside OUT.
- Ordering: ascending, mem[0] smallest, emitted first.
- Widths:
  - Index counters: $clog2(DEPTH) bits.
  - Pass counter: $clog2(DEPTH) bits.
  - No arithmetic on data; data moves only by swapping.

## Timing
- Reset values (at the clock edge with i_rst=1):
  - state=LOAD.
  - all counters=0, swap_flag=0.
  - o_valid=0, o_busy=0, o_done=0, o_data=0.
  - mem contents cleared to 0.
- o_ready is 0 while i_rst is high. It is 1 from the first cycle after i_rst deasserts.
- LOAD->SORT: the cycle after the last accept. o_ready drops in that same cycle.
- SORT: one compare per cycle. The maximum is (DEPTH-1)^2 cycles.
- SORT->OUT: the cycle after the terminating compare. o_done is high for exactly that first OUT cycle.
- OUT handshake:
  - o_data and o_valid are stable while i_ready=0.
  - One word moves per cycle with both signals high.
  - Full throughput is DEPTH cycles.
- OUT->LOAD: the cycle after the last transfer. o_ready=1 in that cycle, so there are no dead cycles between bursts.
- Reset mid-operation (any state): abort to the reset values above. The partial burst is discarded and no o_done is produced.

## Configuration
- SORT_EARLY_EXIT_EN defined:
  - At the end of a pass with swap_flag=0 (including a swap on the final compare of the pass), go to OUT.
  - The first pass of already-sorted data therefore ends SORT after DEPTH-1 cycles.
  - The (DEPTH-1)^2 ceiling still applies.
- SORT_EARLY_EXIT_EN undefined:
  - swap_flag has no effect on control.
  - SORT always lasts exactly (DEPTH-1)^2 cycles, giving deterministic latency.

## Test plan
- Basic sort: reset, then load 8,7,2,15 with i_ready=1 -> o_data sequence 2,7,8,15. o_done pulses once; o_busy is high for 9 cycles without the macro.
- Sorted input: load 1,2,3,4 -> output 1,2,3,4. o_busy is high 3 cycles with SORT_EARLY_EXIT_EN, 9 cycles without.
- Equal and extreme values: load 15,0,15,0 -> 0,0,15,15. Load 5,5,5,5 -> no swaps; output 5,5,5,5.
- Backpressure and ignored inputs:
  - Hold i_ready=0 for 3 cycles on the second output word -> o_data holds 7 and o_valid stays 1; the sequence then resumes.
  - Drive i_valid=1 during SORT/OUT -> no effect on mem contents.
- Reset mid-sort: assert i_rst during the 4th SORT cycle, then load 3,1,2,0 -> output 0,1,2,3. No stale data appears and no extra o_done pulse is produced.
- Back-to-back bursts: keep i_valid=1 during OUT of burst 1. o_ready rises the cycle after the last output transfer; burst 2 (9,4,12,4) -> 4,4,9,12.

Source files
------------

// File: rtl/sort_sequencer_if.sv
// Producer/consumer handshake bundle for sort_sequencer; slave is the sorter side,
// master is the side that feeds words in and drains sorted words out.
interface sort_sequencer_if #(
   parameter int WIDTH = 4
);
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_data;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_data;
   logic             o_busy;
   logic             o_done;

   modport slave (
      input  i_valid, i_data, i_ready,
      output o_ready, o_valid, o_data, o_busy, o_done
   );

   modport master (
      output i_valid, i_data, i_ready,
      input  o_ready, o_valid, o_data, o_busy, o_done
   );
endinterface

// File: rtl/sort_sequencer.sv
// In-place bubble sorter: loads DEPTH words, sorts with one shared compare per cycle, streams ascending.
// SORT lasts (DEPTH-1)^2 cycles; define SORT_EARLY_EXIT_EN to stop after the first swap-free pass.
module greaterThan #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_ab
);
   assign o_ab = (i_a > i_b);
endmodule

module sort_sequencer #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   sort_sequencer_if.slave  bus
);
   localparam int IW = $clog2(DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
   localparam logic [IW-1:0] LAST_CMP = IW'(DEPTH - 2);

   typedef enum logic [1:0] {ST_LOAD, ST_SORT, ST_OUT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [IW-1:0]    wr_idx_q, wr_idx_d;
   logic [IW-1:0]    rd_idx_q, rd_idx_d;
   logic [IW-1:0]    cmp_idx_q, cmp_idx_d;
   logic [IW-1:0]    pass_q, pass_d;
   logic             swap_flag_q, swap_flag_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [IW-1:0]    cmp_nxt;
   logic [WIDTH-1:0] cmp_a, cmp_b;
   logic             cmp_gt;
   logic             end_of_pass;
   logic             sort_finish;

   assign cmp_nxt = cmp_idx_q + 1'b1;
   assign cmp_a   = mem_q[cmp_idx_q];
   assign cmp_b   = mem_q[cmp_nxt];

   greaterThan #(.WIDTH(WIDTH)) u_cmp (
      .i_a  (cmp_a),
      .i_b  (cmp_b),
      .o_ab (cmp_gt)
   );

   assign end_of_pass = (cmp_idx_q == LAST_CMP);

`ifdef SORT_EARLY_EXIT_EN
   // A pass with no swaps, counting the one happening this cycle, means the data is sorted.
   assign sort_finish = end_of_pass && ((pass_q == LAST_CMP) || !(swap_flag_q || cmp_gt));
`else
   assign sort_finish = end_of_pass && (pass_q == LAST_CMP);
`endif

   always_comb begin
      state_d     = state_q;
      mem_d       = mem_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      cmp_idx_d   = cmp_idx_q;
      pass_d      = pass_q;
      swap_flag_d = swap_flag_q;
      valid_d     = valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      case (state_q)
         ST_LOAD: begin
            if (bus.i_valid) begin
               mem_d[wr_idx_q] = bus.i_data;
               if (wr_idx_q == LAST_IDX) begin
                  wr_idx_d = '0;
                  state_d  = ST_SORT;
                  busy_d   = 1'b1;
               end else begin
                  wr_idx_d = wr_idx_q + 1'b1;
               end
            end
         end
         ST_SORT: begin
            // Strict compare keeps equal words in place, so the sort is stable.
            if (cmp_gt) begin
               mem_d[cmp_idx_q] = cmp_b;
               mem_d[cmp_nxt]   = cmp_a;
            end
            if (end_of_pass) begin
               swap_flag_d = 1'b0;
               cmp_idx_d   = '0;
               pass_d      = pass_q + 1'b1;
            end else begin
               swap_flag_d = swap_flag_q | cmp_gt;
               cmp_idx_d   = cmp_nxt;
            end
            if (sort_finish) begin
               state_d     = ST_OUT;
               pass_d      = '0;
               swap_flag_d = 1'b0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               valid_d     = 1'b1;
            end
         end
         ST_OUT: begin
            if (bus.i_ready) begin
               if (rd_idx_q == LAST_IDX) begin
                  rd_idx_d = '0;
                  state_d  = ST_LOAD;
                  valid_d  = 1'b0;
               end else begin
                  rd_idx_d = rd_idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_LOAD;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         cmp_idx_q   <= '0;
         pass_q      <= '0;
         swap_flag_q <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         cmp_idx_q   <= cmp_idx_d;
         pass_q      <= pass_d;
         swap_flag_q <= swap_flag_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Ready is masked by reset so the producer never sees an accept while the block is held.
   assign bus.o_ready = (state_q == ST_LOAD) && !i_rst;
   assign bus.o_valid = valid_q;
   assign bus.o_data  = mem_q[rd_idx_q];
   assign bus.o_busy  = busy_q;
   assign bus.o_done  = done_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer: table-driven bursts plus backpressure, back-to-back and mid-sort reset cases.
module tb_sort_sequencer;
   logic clk = 1'b0;
   logic rst;

   sort_sequencer_if #(.WIDTH(4)) bus ();

   sort_sequencer #(.WIDTH(4), .DEPTH(4)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] din  [4];
      logic [3:0] dout [4];
      int         busy_full;
      int         busy_early;
   } vec_t;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         busy_cnt = 0;
   int         done_cnt = 0;
   logic [3:0] exp_q [$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: pop and compare on every cycle where a transfer is about to happen.
   always @(negedge clk) begin
      if (bus.o_busy) busy_cnt++;
      if (bus.o_done) begin
         done_cnt++;
         check("done_with_valid", int'(bus.o_valid), 1);
      end
      if (bus.o_valid && bus.i_ready) begin
         if (exp_q.size() == 0) begin
            check("out_unexpected", exp_q.size(), 1);
         end else begin
            check("out_word", int'(bus.o_data), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [3:0] w);
      int n;
      n = 0;
      bus.i_valid = 1'b1;
      bus.i_data  = w;
      while (!bus.o_ready && n < 100) begin
         tick();
         n++;
      end
      if (!bus.o_ready) check("load_timeout", int'(bus.o_ready), 1);
      tick();
   endtask

   task automatic load_burst(input logic [3:0] w [4], input bit keep_valid);
      for (int i = 0; i < 4; i++) load_word(w[i]);
      if (!keep_valid) bus.i_valid = 1'b0;
      check("ready_drop_after_load", int'(bus.o_ready), 0);
      check("busy_after_load", int'(bus.o_busy), 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.i_ready = 1'b1;
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
      check("ready_after_out", int'(bus.o_ready), 1);
      check("valid_after_out", int'(bus.o_valid), 0);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!bus.o_valid && n < 100) begin
         tick();
         n++;
      end
      if (!bus.o_valid) check("valid_timeout", int'(bus.o_valid), 1);
   endtask

   function automatic int pick_busy(input vec_t v);
`ifdef SORT_EARLY_EXIT_EN
      return v.busy_early;
`else
      return v.busy_full;
`endif
   endfunction

   vec_t       vecs [4];
   vec_t       bp, b2, rs;
   logic [3:0] abort_w [4];

   initial begin
      vecs[0] = '{'{4'd8, 4'd7, 4'd2, 4'd15},  '{4'd2, 4'd7, 4'd8, 4'd15},  9, 9};
      vecs[1] = '{'{4'd1, 4'd2, 4'd3, 4'd4},   '{4'd1, 4'd2, 4'd3, 4'd4},   9, 3};
      vecs[2] = '{'{4'd15, 4'd0, 4'd15, 4'd0}, '{4'd0, 4'd0, 4'd15, 4'd15}, 9, 9};
      vecs[3] = '{'{4'd5, 4'd5, 4'd5, 4'd5},   '{4'd5, 4'd5, 4'd5, 4'd5},   9, 3};
      bp      = vecs[0];
      b2      = '{'{4'd9, 4'd4, 4'd12, 4'd4},  '{4'd4, 4'd4, 4'd9, 4'd12},  9, 9};
      rs      = '{'{4'd3, 4'd1, 4'd2, 4'd0},   '{4'd0, 4'd1, 4'd2, 4'd3},   9, 9};
      abort_w = '{4'd8, 4'd7, 4'd2, 4'd15};

      rst         = 1'b1;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b0;
      bus.i_data  = '0;
      tick();
      tick();
      check("rst_ready", int'(bus.o_ready), 0);
      check("rst_valid", int'(bus.o_valid), 0);
      check("rst_busy",  int'(bus.o_busy), 0);
      check("rst_done",  int'(bus.o_done), 0);
      check("rst_data",  int'(bus.o_data), 0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", int'(bus.o_ready), 1);
      tick();

      foreach (vecs[k]) begin
         busy_cnt = 0;
         done_cnt = 0;
         for (int i = 0; i < 4; i++) exp_q.push_back(vecs[k].dout[i]);
         load_burst(vecs[k].din, 1'b0);
         drain();
         check($sformatf("busy_cycles_%0d", k), busy_cnt, pick_busy(vecs[k]));
         check($sformatf("done_pulses_%0d", k), done_cnt, 1);
         bus.i_ready = 1'b0;
         tick();
      end

      // Backpressure on word 2, i_valid held through SORT/OUT, then an immediate second burst.
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 4; i++) exp_q.push_back(bp.dout[i]);
      load_burst(bp.din, 1'b1);
      bus.i_data = b2.din[0];
      wait_valid();
      bus.i_ready = 1'b1;
      tick();
      bus.i_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("hold_data", int'(bus.o_data), 7);
         check("hold_valid", int'(bus.o_valid), 1);
         tick();
      end
      drain();
      check("bp_busy_cycles", busy_cnt, pick_busy(bp));
      check("bp_done_pulses", done_cnt, 1);
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 4; i++) exp_q.push_back(b2.dout[i]);
      for (int i = 0; i < 4; i++) load_word(b2.din[i]);
      bus.i_valid = 1'b0;
      check("b2_ready_drop", int'(bus.o_ready), 0);
      drain();
      check("b2_busy_cycles", busy_cnt, pick_busy(b2));
      check("b2_done_pulses", done_cnt, 1);
      bus.i_ready = 1'b0;
      tick();

      // Reset asserted during the 4th SORT cycle aborts the burst without a done pulse.
      done_cnt = 0;
      load_burst(abort_w, 1'b0);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("midrst_busy",  int'(bus.o_busy), 0);
      check("midrst_ready", int'(bus.o_ready), 0);
      check("midrst_valid", int'(bus.o_valid), 0);
      check("midrst_data",  int'(bus.o_data), 0);
      rst = 1'b0;
      tick();
      busy_cnt = 0;
      for (int i = 0; i < 4; i++) exp_q.push_back(rs.dout[i]);
      load_burst(rs.din, 1'b0);
      drain();
      check("rs_busy_cycles", busy_cnt, pick_busy(rs));
      check("rs_done_pulses", done_cnt, 1);
      bus.i_ready = 1'b0;
      tick();
      tick();
      check("leftover_expected", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end
endmodule
